inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000001, meaning the first fetched word address (word 0 is reserved empty).
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the instruction-memory word-address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rom_a  out  ADDR_W  word address to the instruction memory, equal to pc[ADDR_W-1:0].
REQ-006 rom_inst  in  32  instruction word returned combinationally for rom_a.
REQ-007 br_taken / br_target  in  1 / 32  branch redirect from EX.
REQ-008 jmp_taken / jmp_target  in  1 / 32  jump redirect from ID.
REQ-009 id_ready  in  1  decode accepts the IF/ID register this cycle.
REQ-010 id_valid / id_inst / id_pc  out  1 / 32 / 32  IF/ID register contents.

Function
REQ-011 SHALL hold a 32-bit word PC; pc+1 SHALL be computed modulo 2^32, and rom_a SHALL wrap from 6'h3F to 6'h00.
REQ-012 SHALL implement FSM states BOOT, RUN, FLUSH; reset SHALL enter BOOT.
REQ-013 BOOT: one cycle, id_valid=0, pc=RESET_PC; then RUN unconditionally.
REQ-014 RUN: the IF/ID register SHALL load {1, rom_inst, pc} and pc SHALL advance to pc+1 when id_valid=0 or id_ready=1.
REQ-015 RUN with id_valid=1 and id_ready=0 (stall): pc and the IF/ID register SHALL hold unchanged.
REQ-016 Redirect priority SHALL be br_taken > jmp_taken > sequential; a redirect SHALL take effect even when stalled.
REQ-017 On a redirect: pc SHALL load the selected target, the IF/ID register SHALL clear to id_valid=0 with id_inst=32'h00000000, and the FSM SHALL enter FLUSH.
REQ-018 FLUSH: one bubble cycle (id_valid=0); fetch resumes from the new pc; then RUN; a new redirect during FLUSH SHALL restart FLUSH with the newer target.
REQ-019 Latency: an instruction at pc SHALL appear on id_inst exactly one cycle after rom_a=pc and acceptance.
REQ-020 A fetched all-zero word SHALL be passed as a valid NOP and SHALL NOT be treated specially.

Reset
REQ-021 While rst=1: pc=RESET_PC, state=BOOT, id_valid=0, id_inst=32'h0, id_pc=32'h0, and all statistics counters=0.
REQ-022 Reset asserted mid-stall or mid-FLUSH SHALL override all redirect and handshake inputs in the same cycle.

Configuration
REQ-023 With macro INST_FETCH_STATS_EN defined: outputs fetch_cnt[15:0] (count of loads with id_valid=1) and bubble_cnt[15:0] (count of BOOT/FLUSH cycles) SHALL exist, saturate at 16'hFFFF, and clear on rst.
REQ-024 Without INST_FETCH_STATS_EN: those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 The shared CPU package SHALL hold the FSM state encoding (BOOT=2'd0, RUN=2'd1, FLUSH=2'd2), the NOP constant 32'h00000000, and the RESET_PC default.
REQ-026 The IF/ID register SHALL be a sub-module named if_id_reg (load, clear, hold controls); the PC and FSM SHALL stay in inst_fetch.
REQ-027 The instruction memory SHALL remain external, with the interface limited to rom_a/rom_inst.

Verification
REQ-028 Reset release, id_ready=1 held: cycle 1 id_valid=0; rom_a then sequences 01, 02, 03; id_pc=1 with id_inst=rom[1] on the cycle after rom_a=1.
REQ-029 Stall, id_ready=0 for 3 cycles at id_pc=3: id_pc and id_inst hold; rom_a held at 4; the pipeline resumes with id_pc=4 one cycle after id_ready=1.
REQ-030 br_taken=1 with br_target=0x0A and jmp_taken=1 with jmp_target=0x01 in the same cycle: the next cycle has pc=0x0A and a bubble, followed by id_pc=0x0A.
REQ-031 jmp_taken=1 to 0x01 while stalled: the stall is dropped, one bubble follows, then id_pc=0x01.
REQ-032 pc=0x3F sequential: rom_a wraps to 0x00 and id_pc=0x40 with id_inst=rom[0].
REQ-033 With INST_FETCH_STATS_EN: after reset plus 10 unstalled cycles and one redirect, bubble_cnt=2 and fetch_cnt matches the number of id_valid loads; preloading 16'hFFFF shows saturation.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared CPU package for the fetch stage.
// FSM encoding, NOP word, reset PC and the IF/ID bundle.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0001;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Reset beats clear, clear beats load, otherwise hold.
module if_id_reg
  import inst_fetch_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_load,
  input  logic   i_clear,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // Register update: bubble on reset/clear, capture on load.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_q.valid <= 1'b0;
      r_q.inst  <= NOP;
      r_q.pc    <= 32'h0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, BOOT/RUN/FLUSH FSM, IF/ID reg.
// Optional counters enabled by macro INST_FETCH_STATS_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
`ifdef INST_FETCH_STATS_EN
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       bubble_cnt,
`endif
  output logic [ADDR_W-1:0] rom_a,
  input  logic [31:0]       rom_inst,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              jmp_taken,
  input  logic [31:0]       jmp_target,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_inst,
  output logic [31:0]       id_pc
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic         w_load;
  logic         w_clear;
  if_id_t       w_d;
  if_id_t       w_q;

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
    end
  end

  // Next state, next PC and IF/ID controls.
  // BOOT fetches from RESET_PC; FLUSH fetches from the new
  // target. Redirects win over stalls, branch over jump.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_next_state = RUN;
        w_load       = 1'b1;
        w_pc_next    = r_pc + 32'd1;
      end
      RUN, FLUSH: begin
        if (br_taken) begin
          w_next_state = FLUSH;
          w_pc_next    = br_target;
          w_clear      = 1'b1;
        end else if (jmp_taken) begin
          w_next_state = FLUSH;
          w_pc_next    = jmp_target;
          w_clear      = 1'b1;
        end else begin
          w_next_state = RUN;
          if (!w_q.valid || id_ready) begin
            w_load    = 1'b1;
            w_pc_next = r_pc + 32'd1;
          end
        end
      end
      default: w_next_state = BOOT;
    endcase
  end

  assign w_d.valid = 1'b1;
  assign w_d.inst  = rom_inst;
  assign w_d.pc    = r_pc;

  if_id_reg u_if_id (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_d     (w_d),
    .o_q     (w_q)
  );

  assign rom_a    = r_pc[ADDR_W-1:0];
  assign id_valid = w_q.valid;
  assign id_inst  = w_q.inst;
  assign id_pc    = w_q.pc;

`ifdef INST_FETCH_STATS_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_bubble_cnt;
  logic        w_bubble;

  assign w_bubble = (r_state == BOOT) || (r_state == FLUSH);

  // Saturating counters of valid loads and bubble cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt  <= 16'h0;
      r_bubble_cnt <= 16'h0;
    end else begin
      if (w_load && r_fetch_cnt != 16'hFFFF)
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_bubble && r_bubble_cnt != 16'hFFFF)
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch.
// ROM word i holds C0DE_0000+i, word 0 holds a NOP.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  rom_a;
  logic [31:0] rom_inst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_taken;
  logic [31:0] jmp_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef INST_FETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;
`endif

  logic [31:0] rom [64];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom[rom_a];

  inst_fetch dut (
    .clk        (clk),
    .rst        (rst),
`ifdef INST_FETCH_STATS_EN
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .rom_a      (rom_a),
    .rom_inst   (rom_inst),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got %0b want 0", id_valid);
    end
    n_cmp++;
    if (id_inst !== 32'h0 || id_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ifid got %h/%h want 0/0",
               id_inst, id_pc);
    end
    n_cmp++;
    if (rom_a !== 6'h01) begin
      n_fail++;
      $display("FAIL rst_rom_a got %h want 01", rom_a);
    end
  endtask

  task automatic test_seq();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (id_valid !== 1'b0 || rom_a !== 6'h01) begin
      n_fail++;
      $display("FAIL boot got v=%0b a=%h want v=0 a=01",
               id_valid, rom_a);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 32'(i) ||
          id_inst !== 32'hC0DE_0000 + 32'(i) ||
          rom_a !== 6'(i + 1)) begin
        n_fail++;
        $display("FAIL seq%0d got v=%0b pc=%h i=%h a=%h want pc=%h",
                 i, id_valid, id_pc, id_inst, rom_a, i);
      end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== 32'h3 ||
          id_inst !== 32'hC0DE_0003 || rom_a !== 6'h04) begin
        n_fail++;
        $display("FAIL stall%0d got pc=%h i=%h a=%h want 3/C0DE0003/04",
                 i, id_pc, id_inst, rom_a);
      end
    end
    id_ready = 1'b1;
    tick();
    n_cmp++;
    if (id_pc !== 32'h4 || id_inst !== 32'hC0DE_0004 ||
        rom_a !== 6'h05) begin
      n_fail++;
      $display("FAIL resume got pc=%h i=%h a=%h want 4/C0DE0004/05",
               id_pc, id_inst, rom_a);
    end
  endtask

  task automatic test_priority();
    br_taken   = 1'b1;
    br_target  = 32'h0A;
    jmp_taken  = 1'b1;
    jmp_target = 32'h01;
    tick();
    br_taken  = 1'b0;
    jmp_taken = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 ||
        rom_a !== 6'h0A) begin
      n_fail++;
      $display("FAIL prio_bubble got v=%0b i=%h a=%h want 0/0/0A",
               id_valid, id_inst, rom_a);
    end
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0A ||
        id_inst !== 32'hC0DE_000A) begin
      n_fail++;
      $display("FAIL prio_fetch got v=%0b pc=%h i=%h want 1/0A",
               id_valid, id_pc, id_inst);
    end
    tick();
  endtask

  task automatic test_jmp_stall();
    id_ready = 1'b0;
    tick();
    n_cmp++;
    if (id_pc !== 32'h0B || rom_a !== 6'h0C) begin
      n_fail++;
      $display("FAIL jstall_hold got pc=%h a=%h want 0B/0C",
               id_pc, rom_a);
    end
    jmp_taken  = 1'b1;
    jmp_target = 32'h01;
    tick();
    jmp_taken = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || rom_a !== 6'h01) begin
      n_fail++;
      $display("FAIL jstall_bubble got v=%0b a=%h want 0/01",
               id_valid, rom_a);
    end
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h01 ||
        id_inst !== 32'hC0DE_0001) begin
      n_fail++;
      $display("FAIL jstall_fetch got v=%0b pc=%h i=%h want 1/01",
               id_valid, id_pc, id_inst);
    end
    id_ready = 1'b1;
  endtask

  task automatic test_flush_restart();
    br_taken  = 1'b1;
    br_target = 32'h20;
    tick();
    br_taken   = 1'b0;
    jmp_taken  = 1'b1;
    jmp_target = 32'h30;
    tick();
    jmp_taken = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || rom_a !== 6'h30) begin
      n_fail++;
      $display("FAIL reflush got v=%0b a=%h want 0/30",
               id_valid, rom_a);
    end
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h30) begin
      n_fail++;
      $display("FAIL reflush_fetch got v=%0b pc=%h want 1/30",
               id_valid, id_pc);
    end
  endtask

  task automatic test_wrap();
    jmp_taken  = 1'b1;
    jmp_target = 32'h3F;
    tick();
    jmp_taken = 1'b0;
    tick();
    n_cmp++;
    if (id_pc !== 32'h3F || rom_a !== 6'h00) begin
      n_fail++;
      $display("FAIL wrap_a got pc=%h a=%h want 3F/00",
               id_pc, rom_a);
    end
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 ||
        id_inst !== 32'h0 || rom_a !== 6'h01) begin
      n_fail++;
      $display("FAIL wrap_nop got v=%0b pc=%h i=%h a=%h want 1/40/0/01",
               id_valid, id_pc, id_inst, rom_a);
    end
  endtask

  task automatic test_reset_override();
    id_ready = 1'b0;
    tick();
    br_taken  = 1'b1;
    br_target = 32'h15;
    rst       = 1'b1;
    tick();
    n_cmp++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 ||
        id_inst !== 32'h0 || rom_a !== 6'h01) begin
      n_fail++;
      $display("FAIL rst_ovr got v=%0b pc=%h i=%h a=%h want 0/0/0/01",
               id_valid, id_pc, id_inst, rom_a);
    end
    br_taken = 1'b0;
    id_ready = 1'b1;
    rst      = 1'b0;
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h01) begin
      n_fail++;
      $display("FAIL rst_ovr_boot got v=%0b pc=%h want 1/01",
               id_valid, id_pc);
    end
  endtask

`ifdef INST_FETCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (fetch_cnt !== 16'h0 || bubble_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL stats_rst got %h/%h want 0/0",
               fetch_cnt, bubble_cnt);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    jmp_taken  = 1'b1;
    jmp_target = 32'h05;
    tick();
    jmp_taken = 1'b0;
    tick();
    n_cmp++;
    if (fetch_cnt !== 16'd11 || bubble_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL stats_cnt got f=%0d b=%0d want 11/2",
               fetch_cnt, bubble_cnt);
    end
    force dut.r_fetch_cnt = 16'hFFFF;
    tick();
    release dut.r_fetch_cnt;
    tick();
    tick();
    n_cmp++;
    if (fetch_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stats_sat got %h want FFFF", fetch_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
    rom[0]     = 32'h0;
    rst        = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    jmp_taken  = 1'b0;
    jmp_target = 32'h0;
    id_ready   = 1'b1;
    test_reset();
    test_seq();
    test_stall();
    test_priority();
    test_jmp_stall();
    test_flush_restart();
    test_wrap();
    test_reset_override();
`ifdef INST_FETCH_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
